// File: rtl/pixel_enc_pkg.sv
// Shared types and constants for the pixel hit encoder.
package pixel_enc_pkg;

  localparam int unsigned TAG_W     = 8;
  localparam int unsigned HIT_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSnap,
    StScan,
    StDone
  } enc_state_e;

endpackage

// File: rtl/pixel_prio_enc.sv
// Lowest-set-bit priority encoder for one pixel group.
module pixel_prio_enc #(
  parameter int unsigned W = 8,
  localparam int unsigned IdxW = $clog2(W)
) (
  input  logic [W-1:0]    bits_i,
  output logic [IdxW-1:0] idx_o,
  output logic            nz_o
);

  // Scan from the top so the last write wins with the lowest set index.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (bits_i[i]) idx_o = IdxW'(i);
    end
  end

  assign nz_o = |bits_i;

endmodule

// File: rtl/pixel_hit_encoder.sv
// Frame-snapshot pixel hit encoder with a registered output FIFO.
// Optional frame tag in each word: define PIXEL_ENC_FRAME_TAG_EN.
module pixel_hit_encoder
  import pixel_enc_pkg::*;
#(
  parameter int unsigned NUM_GROUPS = 16,
  parameter int unsigned GROUP_W    = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned ADDR_W    = $clog2(NUM_GROUPS) + $clog2(GROUP_W),
  localparam int unsigned NPIX      = NUM_GROUPS * GROUP_W,
`ifdef PIXEL_ENC_FRAME_TAG_EN
  localparam int unsigned OUT_W     = ADDR_W + TAG_W
`else
  localparam int unsigned OUT_W     = ADDR_W
`endif
) (
  input  logic                 clk,
  input  logic                 reset_pe,
  input  logic                 en,
  input  logic                 start,
  input  logic [NPIX-1:0]      state,
  output logic [NPIX-1:0]      pix_reset,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 full,
  output logic                 empty,
  output logic [HIT_CNT_W-1:0] hit_count
);

  localparam int unsigned GidxW = $clog2(NUM_GROUPS);
  localparam int unsigned LidxW = $clog2(GROUP_W);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  enc_state_e           st_q, st_d;
  logic [NPIX-1:0]      snap_q, snap_d;
  logic [GidxW-1:0]     g_q, g_d;
  logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [NPIX-1:0]      pix_reset_q, pix_reset_d;

  logic [GROUP_W-1:0]   grp_bits;
  logic [LidxW-1:0]     l_idx;
  logic                 grp_nz;
  logic [ADDR_W-1:0]    hit_addr;
  logic                 push_req, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [OUT_W-1:0]     push_word;

  logic [OUT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PtrW:0]        wptr_q, rptr_q;

  assign grp_bits = snap_q[{g_q, {LidxW{1'b0}}} +: GROUP_W];
  assign hit_addr = {g_q, l_idx};

  pixel_prio_enc #(
    .W (GROUP_W)
  ) u_prio (
    .bits_i (grp_bits),
    .idx_o  (l_idx),
    .nz_o   (grp_nz)
  );

  always_comb begin
    st_d        = st_q;
    snap_d      = snap_q;
    g_d         = g_q;
    hit_cnt_d   = hit_cnt_q;
    pix_reset_d = '0;
    push_req    = 1'b0;
    if (en) begin
      unique case (st_q)
        StIdle: if (start) st_d = StSnap;
        StSnap: begin
          snap_d    = state;
          g_d       = '0;
          hit_cnt_d = '0;
          st_d      = StScan;
        end
        StScan: begin
          if (grp_nz) begin
            push_req = 1'b1;
            // A full FIFO stalls the scan with the snapshot untouched.
            if (!fifo_full) begin
              snap_d[hit_addr]      = 1'b0;
              pix_reset_d[hit_addr] = 1'b1;
              if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + HIT_CNT_W'(1);
            end
          end else if (g_q == GidxW'(NUM_GROUPS - 1)) begin
            st_d = StDone;
          end else begin
            g_d = g_q + GidxW'(1);
          end
        end
        StDone:  st_d = StIdle;
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_pe) begin
    if (reset_pe) begin
      st_q        <= StIdle;
      snap_q      <= '0;
      g_q         <= '0;
      hit_cnt_q   <= '0;
      pix_reset_q <= '0;
    end else begin
      st_q        <= st_d;
      snap_q      <= snap_d;
      g_q         <= g_d;
      hit_cnt_q   <= hit_cnt_d;
      pix_reset_q <= pix_reset_d;
    end
  end

`ifdef PIXEL_ENC_FRAME_TAG_EN
  logic [TAG_W-1:0] frame_q;

  always_ff @(posedge clk or posedge reset_pe) begin
    if (reset_pe) begin
      frame_q <= '0;
    end else if (en && st_q == StDone) begin
      frame_q <= frame_q + TAG_W'(1);
    end
  end

  assign push_word = {frame_q, hit_addr};
`else
  assign push_word = hit_addr;
`endif

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                      (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign push       = push_req && !fifo_full;
  assign pop        = !fifo_empty && out_ready;

  always_ff @(posedge clk or posedge reset_pe) begin
    if (reset_pe) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (PtrW + 1)'(1);
      if (pop)  rptr_q <= rptr_q + (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PtrW-1:0]] <= push_word;
  end

  assign out_data   = fifo_empty ? '0 : mem_q[rptr_q[PtrW-1:0]];
  assign out_valid  = !fifo_empty;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign busy       = (st_q != StIdle);
  assign frame_done = (st_q == StDone);
  assign hit_count  = hit_cnt_q;
  assign pix_reset  = pix_reset_q;

endmodule

// File: tb/tb_pixel_hit_encoder.sv
// Self-checking bench for pixel_hit_encoder: vector table, corner sequences, random frames.
module tb_pixel_hit_encoder;
  import pixel_enc_pkg::*;

  localparam int unsigned NUM_GROUPS = 16;
  localparam int unsigned GROUP_W    = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned NPIX       = NUM_GROUPS * GROUP_W;
  localparam int unsigned ADDR_W     = 7;
`ifdef PIXEL_ENC_FRAME_TAG_EN
  localparam int unsigned OUT_W      = ADDR_W + TAG_W;
`else
  localparam int unsigned OUT_W      = ADDR_W;
`endif

  logic                 clk, reset_pe, en, start, out_ready;
  logic [NPIX-1:0]      state, pix_reset;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid, busy, frame_done, full, empty;
  logic [HIT_CNT_W-1:0] hit_count;

  pixel_hit_encoder #(
    .NUM_GROUPS (NUM_GROUPS),
    .GROUP_W    (GROUP_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset_pe   (reset_pe),
    .en         (en),
    .start      (start),
    .state      (state),
    .pix_reset  (pix_reset),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .full       (full),
    .empty      (empty),
    .hit_count  (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OUT_W-1:0] got_q[$];
  int fd_cnt, busy_cnt, frame_cnt;
  int pr_cnt[NPIX];

  // Passive monitor: records transfers, done pulses, busy cycles and pixel clears.
  always @(posedge clk) begin
    if (!reset_pe) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_done) fd_cnt++;
      if (busy) busy_cnt++;
      for (int p = 0; p < NPIX; p++) if (pix_reset[p]) pr_cnt[p]++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [NPIX-1:0] s, input int mode, input int hold,
                           input int pause, input string name);
    int exp_q[$];
    int bad, hc, exp_hc;
    bit done;
    got_q.delete();
    fd_cnt   = 0;
    busy_cnt = 0;
    foreach (pr_cnt[i]) pr_cnt[i] = 0;
    // Reference: hits come out in ascending pixel index order.
    for (int p = 0; p < NPIX; p++) if (s[p]) exp_q.push_back(p);
    state     = s;
    en        = 1'b1;
    start     = 1'b1;
    out_ready = (hold > 0) ? 1'b0 : 1'b1;
    step;
    start = 1'b0;
    step;
    for (int p = 0; p < NPIX; p++) state[p] = 1'($urandom_range(0, 1));
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (hold > 0 && cyc == hold) begin
        check({name, "_full"}, full, 1);
        check({name, "_stall_hits"}, hit_count, FIFO_DEPTH);
        check({name, "_stall_nopulse"}, (pix_reset == '0), 1);
      end
      if (pause > 0 && cyc == pause) begin
        en = 1'b0;
        hc = hit_count;
        repeat (10) begin
          out_ready = 1'b1;
          step;
        end
        check({name, "_frozen_hits"}, hit_count, hc);
        check({name, "_drained"}, empty, 1);
        check({name, "_frozen_busy"}, busy, 1);
        en = 1'b1;
      end
      out_ready = (cyc < hold) ? 1'b0 : ((mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
      step;
      if (fd_cnt > 0 && empty) done = 1'b1;
    end
    check({name, "_finished"}, done, 1);
    frame_cnt++;
    check({name, "_nwords"}, got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i >= exp_q.size() || int'(got_q[i][ADDR_W-1:0]) != exp_q[i]) bad++;
`ifdef PIXEL_ENC_FRAME_TAG_EN
      if (int'(got_q[i][OUT_W-1:ADDR_W]) != (frame_cnt - 1) % 256) bad++;
`endif
    end
    check({name, "_word_errs"}, bad, 0);
    exp_hc = (exp_q.size() > 65535) ? 65535 : exp_q.size();
    check({name, "_hit_count"}, hit_count, exp_hc);
    check({name, "_frame_done"}, fd_cnt, 1);
    bad = 0;
    for (int p = 0; p < NPIX; p++) if (pr_cnt[p] != int'(s[p])) bad++;
    check({name, "_pix_reset_errs"}, bad, 0);
    if (mode == 0 && hold == 0 && pause == 0)
      check({name, "_busy_cycles"}, busy_cnt, 2 + NUM_GROUPS + exp_q.size());
  endtask

  typedef struct {
    string           name;
    logic [NPIX-1:0] st;
    int              mode;
    int              hold;
    int              pause;
    int              exp_hits;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [NPIX-1:0] tmp;
    reset_pe  = 1'b1;
    en        = 1'b0;
    start     = 1'b0;
    state     = '0;
    out_ready = 1'b0;
    frame_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_hits", hit_count, 0);
    check("rst_data", out_data, 0);
    check("rst_pix_reset", (pix_reset == '0), 1);
    reset_pe = 1'b0;
    step;

    tmp = '0; tmp[0] = 1'b1; tmp[9] = 1'b1; tmp[127] = 1'b1;
    vecs[0] = '{"three_hits", tmp, 0, 0, 0, 3};
    tmp = '0;
    vecs[1] = '{"empty_frame", tmp, 0, 0, 0, 0};
    tmp = '1;
    vecs[2] = '{"all_ones_stall", tmp, 0, 30, 0, 128};
    vecs[3] = '{"all_ones_rand_ready", tmp, 1, 0, 0, 128};
    vecs[5] = '{"en_pause", tmp, 0, 0, 20, 128};
    tmp = '0; tmp[64] = 1'b1;
    vecs[4] = '{"single", tmp, 0, 0, 0, 1};
    tmp = {16{8'h55}};
    vecs[6] = '{"alternating", tmp, 1, 0, 0, 64};
    tmp = '0; tmp[127:120] = 8'hFF;
    vecs[7] = '{"last_group", tmp, 0, 0, 0, 8};

    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].st, vecs[v].mode, vecs[v].hold, vecs[v].pause, vecs[v].name);
      check({vecs[v].name, "_tbl_hits"}, got_q.size(), vecs[v].exp_hits);
      if (v == 0 && got_q.size() == 3) begin
        check("three_hits_w0", got_q[0][ADDR_W-1:0], 'h00);
        check("three_hits_w1", got_q[1][ADDR_W-1:0], 'h09);
        check("three_hits_w2", got_q[2][ADDR_W-1:0], 'h7F);
      end
    end

    // Reset in the middle of a scan after five pushes.
    state     = '1;
    en        = 1'b1;
    out_ready = 1'b0;
    start     = 1'b1;
    step;
    start = 1'b0;
    step;
    repeat (5) step;
    check("midscan_hits", hit_count, 5);
    check("midscan_valid", out_valid, 1);
    #2 reset_pe = 1'b1;
    #1;
    check("midscan_rst_empty", empty, 1);
    check("midscan_rst_busy", busy, 0);
    check("midscan_rst_valid", out_valid, 0);
    check("midscan_rst_hits", hit_count, 0);
    check("midscan_rst_pix", (pix_reset == '0), 1);
    step;
    reset_pe  = 1'b0;
    frame_cnt = 0;
    step;
    check("post_rst_pix", (pix_reset == '0), 1);
    check("post_rst_busy", busy, 0);
    tmp = '0; tmp[5] = 1'b1; tmp[100] = 1'b1;
    run_frame(tmp, 0, 0, 0, "post_reset");

    for (int r = 0; r < 15; r++) begin
      int thr;
      thr = $urandom_range(0, 100);
      for (int p = 0; p < NPIX; p++) tmp[p] = ($urandom_range(0, 99) < thr);
      run_frame(tmp, int'($urandom_range(0, 1)), 0, 0, $sformatf("rand%0d", r));
    end

`ifdef PIXEL_ENC_FRAME_TAG_EN
    reset_pe = 1'b1;
    step;
    reset_pe  = 1'b0;
    frame_cnt = 0;
    step;
    tmp = '0; tmp[3] = 1'b1;
    for (int f = 0; f < 257; f++) run_frame(tmp, 0, 0, 0, $sformatf("tag%0d", f));
    if (got_q.size() > 0) check("tag_wrap_last", got_q[0][OUT_W-1:ADDR_W], 0);
    else check("tag_wrap_present", got_q.size(), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_hit_encoder.md
PIXEL_HIT_ENCODER -- requirements
Module: pixel_hit_encoder

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 16, number of pixel groups (power of 2, >=2).
REQ-002 SHALL have parameter GROUP_W, default 8, pixels per group (power of 2, >=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, hit FIFO entries (power of 2, >=2).
REQ-004 SHALL derive ADDR_W = $clog2(NUM_GROUPS) + $clog2(GROUP_W); default 7.
REQ-005 Ports: clk  in  1  single clock; all logic on posedge.
REQ-006 Ports: reset_pe  in  1  asynchronous, active-high reset.
REQ-007 Ports: en  in  1  scan enable; low freezes the scan FSM only.
REQ-008 Ports: start  in  1  begin frame readout (sampled in IDLE).
REQ-009 Ports: state  in  NUM_GROUPS*GROUP_W  pixel hit flags; pixel p = state[p].
REQ-010 Ports: pix_reset  out  NUM_GROUPS*GROUP_W  one-cycle clear pulse to each encoded pixel.
REQ-011 Ports: out_data  out  OUT_W  hit word {group, local} (+ tag, REQ-030).
REQ-012 Ports: out_valid  out  1 / out_ready  in  1  valid/ready output handshake.
REQ-013 Ports: busy, frame_done, full, empty  out  1 each; hit_count  out  16.

Function
REQ-014 FSM states SHALL be IDLE, SNAP, SCAN, DONE.
REQ-015 IDLE -> SNAP when en & start; start in any other state ignored.
REQ-016 SNAP SHALL register state into a snapshot, clear group index g and hit_count, go to SCAN; 1 cycle.
REQ-017 SCAN, snapshot group g nonzero, FIFO not full: encode lowest set bit l, push {g,l}, clear bit l in snapshot, pulse pix_reset[g*GROUP_W+l] next cycle, hit_count+1 (saturating at 0xFFFF).
REQ-018 SCAN, group g zero: g+1 same cycle, no push; when g = NUM_GROUPS-1 and group zero -> DONE.
REQ-019 SCAN, FIFO full: stall; no push, no snapshot change, no pix_reset pulse.
REQ-020 Push SHALL be blocked while full even with simultaneous pop (no write-through).
REQ-021 DONE: frame_done high 1 cycle, -> IDLE.
REQ-022 busy SHALL be high in SNAP, SCAN, DONE.
REQ-023 en low: FSM, snapshot, g, hit_count hold; FIFO pops continue.
REQ-024 FIFO SHALL be registered: out_valid = !empty; word pushed into empty FIFO visible 1 cycle later.
REQ-025 Transfer on out_valid & out_ready; out_data stable while out_valid & !out_ready.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty from an extra wrap bit.
REQ-027 Hits set in state after SNAP SHALL be ignored until the next frame.

Reset
REQ-028 reset_pe SHALL asynchronously force IDLE, g=0, snapshot=0, FIFO empty (empty=1, full=0, out_valid=0), pix_reset=0, frame_done=0, busy=0, hit_count=0, out_data=0.
REQ-029 Reset mid-SCAN SHALL discard unread hits; no pix_reset pulses for them.

Configuration
REQ-030 With PIXEL_ENC_FRAME_TAG_EN defined: 8-bit frame counter, +1 per DONE, wraps 255->0, reset 0; OUT_W = ADDR_W+8, out_data = {tag, group, local}.
REQ-031 Without PIXEL_ENC_FRAME_TAG_EN: no counter; OUT_W = ADDR_W.

Structure
REQ-032 Package pixel_enc_pkg SHALL hold the FSM state enum, TAG_W=8, HIT_CNT_W=16.
REQ-033 Sub-module pixel_prio_enc SHALL provide parametrised lowest-set-bit encode (index + nonzero flag) of one GROUP_W group.

Verification
REQ-034 Defaults; state bits 0,9,127 set; start; out_ready=1 -> out_data 0x00, 0x09, 0x7F in order; hit_count=3; frame_done once.
REQ-035 All 128 bits set, out_ready=0 -> 16 pushes, full=1, scan stalls; out_ready=1 -> all 128 words 0x00..0x7F delivered, no loss/duplicate.
REQ-036 state=0, start -> SNAP, 16 SCAN cycles, DONE; no out_valid; hit_count=0.
REQ-037 reset_pe asserted mid-SCAN after 5 pushes -> same-cycle empty=1, busy=0; subsequent start works.
REQ-038 en=0 for 10 cycles mid-SCAN -> g and hit_count frozen, queued words still drain.
REQ-039 PIXEL_ENC_FRAME_TAG_EN, 257 frames with bit 3 set -> tag of last word = 0x00.
